// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters
//   (0 = EX stage, 1 = branch/address-calc). Round-robin grant, registered
//   operand issue to the ALU, registered result/flag capture and the
//   architectural NZVC flag register.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     per-requester request handshake (bit i = requester i)
//   req_a/req_b/req_op      operands and ALU control, requester i at [i*W +: W]
//   req_setf                op writes the flag register
//   rsp_valid/rsp_ready     one-hot response handshake back to the owner
//   rsp_result/rsp_flags    registered result and NZVC of the granted op
//   alu_a/alu_b/alu_op      registered operands/control to the shared ALU
//   alu_result/alu_flags    ALU outputs, sampled at the end of EXEC
//   flag_reg                architectural NZVC ([3]N [2]Z [1]V [0]C)
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int OPW   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [2*OPW-1:0]   req_op,
    input  logic [1:0]         req_setf,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [3:0]         rsp_flags,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OPW-1:0]     alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [3:0]         alu_flags,
    output logic [3:0]         flag_reg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   rr_ptr;     // requester preferred on the next contended grant
    logic   owner;      // requester whose op is in flight
    logic   setf_q;     // in-flight op updates flag_reg
    logic   grant;
    logic   grant_vld;
    logic   accept;

    // Round-robin pick: preferred requester first, otherwise the other one.
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        if (req_valid[rr_ptr]) begin
            grant     = rr_ptr;
            grant_vld = 1'b1;
        end else if (req_valid[~rr_ptr]) begin
            grant     = ~rr_ptr;
            grant_vld = 1'b1;
        end
    end

    // Ready is suppressed while reset is held so nothing is accepted then.
    assign accept = (state == IDLE) && grant_vld && !reset;

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            setf_q     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            flag_reg   <= '0;
        end else begin
            if (accept) begin
                alu_a  <= grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                alu_b  <= grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                alu_op <= grant ? req_op[2*OPW-1:OPW]    : req_op[OPW-1:0];
                setf_q <= req_setf[grant];
                owner  <= grant;
                rr_ptr <= ~grant;
            end
            // ALU output is settled from the registered operands by end of EXEC.
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                if (setf_q) flag_reg <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W  = 64;
    localparam int OW = 3;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*W-1:0]  req_a = '0;
    logic [2*W-1:0]  req_b = '0;
    logic [2*OW-1:0] req_op = '0;
    logic [1:0]      req_setf = 2'b00;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = 2'b11;
    logic [W-1:0]    rsp_result;
    logic [3:0]      rsp_flags;
    logic [W-1:0]    alu_a, alu_b;
    logic [OW-1:0]   alu_op;
    logic [W-1:0]    alu_result;
    logic [3:0]      alu_flags;
    logic [3:0]      flag_reg;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_setf(req_setf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flag_reg(flag_reg)
    );

    // Shared ALU: returns {N,Z,V,C, result}; SUB carry is "no borrow".
    function automatic logic [67:0] alu_f(logic [63:0] a, logic [63:0] b, logic [2:0] op);
        logic [64:0] s;
        logic [63:0] r;
        logic        c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0]; c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[63:0]; c = s[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            default: r = '0;
        endcase
        return {r[63], (r == 64'd0), v, c, r};
    endfunction

    assign {alu_flags, alu_result} = alu_f(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [1:0] v, int pref);
        if (v[pref])   return pref;
        if (v[1-pref]) return 1 - pref;
        return -1;
    endfunction

    // Transaction-level model: one op in flight, which is in its ALU cycle
    // (age 0) or waiting for the owner to take the response (age 1).
    // Checked at every negedge, then advanced for the coming posedge.
    initial begin : model
        logic        m_busy;
        int          m_age, m_owner, m_pref, g;
        logic [63:0] m_a, m_b, m_res;
        logic [2:0]  m_op;
        logic        m_setf;
        logic [3:0]  m_flg, m_freg;
        logic [1:0]  e_rdy, e_vld;
        logic [67:0] o;
        m_busy = 0; m_age = 0; m_owner = 0; m_pref = 0;
        m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_setf = 0; m_flg = 0; m_freg = 0;
        forever begin
            @(negedge clk);
            g     = pick(req_valid, m_pref);
            e_rdy = (!reset && !m_busy && g >= 0) ? (2'b01 << g) : 2'b00;
            e_vld = (m_busy && m_age == 1) ? (2'b01 << m_owner) : 2'b00;
            check("req_ready", req_ready, e_rdy);
            check("rsp_valid", rsp_valid, e_vld);
            check("rsp_result", rsp_result, m_res);
            check("rsp_flags", rsp_flags, m_flg);
            check("flag_reg", flag_reg, m_freg);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_op", alu_op, m_op);
            if (reset) begin
                m_busy = 0; m_age = 0; m_owner = 0; m_pref = 0;
                m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_setf = 0; m_flg = 0; m_freg = 0;
            end else if (!m_busy) begin
                if (g >= 0) begin
                    m_busy = 1; m_age = 0; m_owner = g; m_pref = 1 - g;
                    m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W];
                    m_op = req_op[g*OW +: OW]; m_setf = req_setf[g];
                end
            end else if (m_age == 0) begin
                o = alu_f(m_a, m_b, m_op);
                m_res = o[63:0]; m_flg = o[67:64];
                if (m_setf) m_freg = m_flg;
                m_age = 1;
            end else if (rsp_ready[m_owner]) begin
                m_busy = 0;
            end
        end
    end

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] op, input logic s);
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
        req_op[i*OW +: OW] = op;
        req_setf[i]        = s;
    endtask

    // Returns just after the posedge where requester i was accepted.
    task automatic wait_grant(input int i, output logic [1:0] seen);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (req_ready[i]) break;
        end
        seen = req_ready;
        check($sformatf("grant_wait_%0d", i), {63'd0, req_ready[i]}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_any(output int g);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (req_ready != 2'b00) break;
        end
        check("any_grant_wait", {63'd0, (req_ready != 2'b00)}, 64'd1);
        g = req_ready[1] ? 1 : 0;
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int i, output int lat, output logic [63:0] res,
                            output logic [3:0] flg, output logic [3:0] freg);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk); lat++;
            if (rsp_valid[i]) break;
        end
        check($sformatf("rsp_wait_%0d", i), {63'd0, rsp_valid[i]}, 64'd1);
        res = rsp_result; flg = rsp_flags; freg = flag_reg;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [1:0]  seen;
        logic [63:0] res;
        logic [3:0]  flg, freg;
        int          lat, g;

        // Reset with both requesting
        set_req(0, 64'hF0F0, 64'h0FF0, OP_AND, 1'b1);
        set_req(1, 64'hFF00, 64'h00FF, OP_AND, 1'b1);
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_flag_reg", flag_reg, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single op from req 0, then zero-flag op from req 1 (waiting loser)
        wait_grant(0, seen);
        check("first_grant", seen, 2'b01);
        req_valid = 2'b10;
        wait_rsp(0, lat, res, flg, freg);
        check("t2_latency", lat, 2);
        check("t2_result", res, 64'h00F0);
        check("t2_flags", flg, 4'b0000);
        check("t2_flag_reg", freg, 4'b0000);

        wait_grant(1, seen);
        check("t3_grant", seen, 2'b10);
        req_valid = 2'b00;
        set_req(1, 64'h1, 64'h2, OP_OR, 1'b0);
        wait_rsp(1, lat, res, flg, freg);
        check("t3_result", res, 64'h0);
        check("t3_flags", flg, 4'b0100);
        check("t3_flag_reg", freg, 4'b0100);

        // Non-flag-setting op leaves flag_reg alone
        req_valid = 2'b10;
        wait_grant(1, seen);
        req_valid = 2'b00;
        wait_rsp(1, lat, res, flg, freg);
        check("t3b_result", res, 64'h3);
        check("t3b_flag_reg", freg, 4'b0100);

        // Contention: both valid for 8 ops, grants must alternate from req 0
        set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 1'b1);
        set_req(1, 64'h0, 64'h1, OP_SUB, 1'b1);
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            wait_any(g);
            check($sformatf("rr_order_%0d", k), g, k % 2);
            wait_rsp(g, lat, res, flg, freg);
            if (g == 0) begin
                check("t4_add_result", res, 64'h8000_0000_0000_0000);
                check("t4_add_flags", flg, 4'b1010);
            end else begin
                check("t4_sub_result", res, 64'hFFFF_FFFF_FFFF_FFFF);
                check("t4_sub_flags", flg, 4'b1000);
            end
        end
        req_valid = 2'b00;

        // Backpressure on req 0; req 1 ready/valid must not interfere
        rsp_ready = 2'b10;
        set_req(0, 64'hAAAA, 64'h0F0F, OP_AND, 1'b0);
        req_valid = 2'b01;
        wait_grant(0, seen);
        req_valid = 2'b10;
        wait_rsp(0, lat, res, flg, freg);
        check("t5_result", res, 64'h0A0A);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("t5_hold_valid", rsp_valid, 2'b01);
            check("t5_hold_result", rsp_result, 64'h0A0A);
            check("t5_hold_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("t5_idle_after", req_ready, 2'b10);
        check("t5_valid_drop", rsp_valid, 2'b00);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(1, lat, res, flg, freg);
        check("t5_req1_flag_reg", freg, 4'b1000);

        // Reset while in EXEC: op discarded, flags cleared, pointer back to 0
        set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 1'b1);
        req_valid = 2'b01;
        wait_grant(0, seen);
        reset = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 2'b00);
            check("t6_flag_reg", flag_reg, 4'b0000);
        end
        @(posedge clk); #1;
        req_valid = 2'b11;
        wait_grant(0, seen);
        check("t6_rr_reset", seen, 2'b01);
        req_valid = 2'b00;
        wait_rsp(0, lat, res, flg, freg);
        check("t6_flags", flg, 4'b1010);
        check("t6_flag_reg_after", freg, 4'b1010);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
